branch_resolve_ctrl: RTL and testbench

- Sequences the 2-bit branch predictor against pipeline resolution.
- Records each control-flow instruction fetched with its prediction in a small in-order tracking queue.
- Compares the oldest entry with the EX-stage outcome; on a mispredict, drives flush and redirect and blocks fetch for a fixed recovery window.
- Issues one-cycle predictor update pulses for conditional branches.

---
 rtl/brc_pkg.sv | 32 +++
 rtl/brc_queue.sv | 58 +++++
 rtl/branch_resolve_ctrl.sv | 174 +++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared types and constants for the branch resolution controller.
package brc_pkg;

    // Default RISC-V control-flow opcodes.
    localparam logic [6:0] BR_OPCODE   = 7'h63;
    localparam logic [6:0] JAL_OPCODE  = 7'h6F;
    localparam logic [6:0] JALR_OPCODE = 7'h67;

    // Address fields in queue entries are stored at this width.
    // The top zero-extends narrower PCs into them, so XLEN must not exceed it.
    localparam int unsigned PC_W_MAX = 64;

    typedef enum logic [1:0] {
        CF_BR,
        CF_JAL,
        CF_JALR
    } cf_class_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FLUSH
    } brc_state_t;

    typedef struct packed {
        cf_class_t             cls;
        logic [PC_W_MAX-1:0]   pc;
        logic                  pred_taken;
        logic [PC_W_MAX-1:0]   pred_target;
    } brc_entry_t;

endpackage

// File: rtl/brc_queue.sv
// In-order tracking FIFO of brc_entry_t with push, pop, clear and occupancy.
// Clear has priority over push and pop. The caller must never push when full
// or pop when empty.
module brc_queue
    import brc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  brc_entry_t                i_push_data,
    input  logic                      i_pop,
    input  logic                      i_clear,
    output brc_entry_t                o_head,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    brc_entry_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    // Entry storage. It is written only at the tail.
    // NOTE: storage has no reset. The valid window is defined only by the pointers and count, so resetting the array would add reset fan-out and change nothing.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping. The pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments only. This keeps every flop reading its pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (i_push && !i_pop)      r_count <= r_count + CNT_ONE;
            else if (i_pop && !i_push) r_count <= r_count - CNT_ONE;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller. It tracks fetched control-flow instructions with
// their predictions, resolves them in order against EX outcomes, and drives the
// flush/redirect recovery and the predictor update strobes.
// Optional build macro BRC_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_ctrl
    import brc_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [6:0]  bOp          = BR_OPCODE,
    parameter logic [6:0]  jalOp        = JAL_OPCODE,
    parameter logic [6:0]  jalrOp       = JALR_OPCODE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_valid,
    input  logic [6:0]                if_opCode,
    input  logic [XLEN-1:0]           if_pc,
    input  logic                      pred_taken,
    input  logic [XLEN-1:0]           pred_target,
    input  logic                      ex_valid,
    input  logic                      ex_taken,
    input  logic [XLEN-1:0]           ex_target,
    output logic                      stall_if,
    output logic                      flush,
    output logic                      redirect_valid,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      upd_valid,
    output logic                      upd_taken,
    output logic [$clog2(DEPTH):0]    count
`ifdef BRC_STATS_EN
    ,
    output logic [15:0]               stat_resolved,
    output logic [15:0]               stat_mispred
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    brc_state_t      r_state, w_state_nxt;
    logic [FW-1:0]   r_flush_cnt, w_flush_cnt_nxt;
    logic            w_is_cf;
    cf_class_t       w_class;
    brc_entry_t      w_new_entry;
    brc_entry_t      w_head;
    logic [CW-1:0]   w_count;
    logic            w_alloc;
    logic            w_resolve;
    logic            w_mispredict;
    logic            w_head_is_br;

    // Classify the IF opcode. Anything that is not a control-flow opcode is never queued.
    // NOTE: every combinational output gets a default first. Without it, a path that skips an assignment infers a latch.
    always_comb begin
        w_is_cf = 1'b1;
        w_class = CF_BR;
        if (if_opCode == bOp)         w_class = CF_BR;
        else if (if_opCode == jalOp)  w_class = CF_JAL;
        else if (if_opCode == jalrOp) w_class = CF_JALR;
        else                          w_is_cf = 1'b0;
    end

    // Build the entry that is pushed at the tail on allocation.
    always_comb begin
        w_new_entry = '{cls:         w_class,
                        pc:          PC_W_MAX'(if_pc),
                        pred_taken:  pred_taken,
                        pred_target: PC_W_MAX'(pred_target)};
    end

    assign stall_if     = (w_count == DEPTH_C) || (r_state == FLUSH);
    assign flush        = (r_state == FLUSH);
    assign count        = w_count;
    assign w_alloc      = if_valid && w_is_cf && !stall_if;
    assign w_resolve    = ex_valid && (w_count != '0) && (r_state != FLUSH);
    assign w_head_is_br = (w_head.cls == CF_BR);
    assign w_mispredict = w_resolve &&
                          ((ex_taken != w_head.pred_taken) ||
                           (ex_taken && w_head.pred_taken &&
                            (w_head.pred_target != PC_W_MAX'(ex_target))));

    brc_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_alloc),
        .i_push_data (w_new_entry),
        .i_pop       (w_resolve),
        .i_clear     (w_mispredict),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // FSM state register and flush-window down-counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next-state logic. A mispredict takes priority over draining to IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_alloc) w_state_nxt = TRACK;
            end
            TRACK: begin
                if (w_mispredict) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else if (w_resolve && !w_alloc && (w_count == ONE_C)) begin
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == '0) w_state_nxt = IDLE;
                else                   w_flush_cnt_nxt = r_flush_cnt - FW'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered one-cycle redirect and predictor-update strobes.
    // The data outputs hold their value between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            upd_valid      <= 1'b0;
            upd_taken      <= 1'b0;
        end else begin
            redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                redirect_pc <= ex_taken ? ex_target : XLEN'(w_head.pc + PC_W_MAX'(4));
            end
            upd_valid <= w_resolve && w_head_is_br;
            if (w_resolve && w_head_is_br) begin
                upd_taken <= ex_taken;
            end
        end
    end

`ifdef BRC_STATS_EN
    logic [15:0] r_stat_resolved;
    logic [15:0] r_stat_mispred;

    // Saturating counters of accepted resolves and of mispredicts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_resolve && (r_stat_resolved != 16'hFFFF))
                r_stat_resolved <= r_stat_resolved + 16'd1;
            if (w_mispredict && (r_stat_mispred != 16'hFFFF))
                r_stat_mispred <= r_stat_mispred + 16'd1;
        end
    end

    assign stat_resolved = r_stat_resolved;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl using default parameters.
module tb_branch_resolve_ctrl;

    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [6:0]  if_opCode;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        stall_if;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_taken;
    logic [2:0]  count;
`ifdef BRC_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispred;
`endif

    int n_total = 0;
    int n_bad   = 0;

    branch_resolve_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_opCode      (if_opCode),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .stall_if       (stall_if),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_taken      (upd_taken),
        .count          (count)
`ifdef BRC_STATS_EN
        ,
        .stat_resolved  (stat_resolved),
        .stat_mispred   (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        if_valid    = 1'b0;
        if_opCode   = 7'h00;
        if_pc       = '0;
        pred_taken  = 1'b0;
        pred_target = '0;
        ex_valid    = 1'b0;
        ex_taken    = 1'b0;
        ex_target   = '0;
    endtask

    task automatic fetch(input logic [6:0] op, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptgt);
        if_valid    = 1'b1;
        if_opCode   = op;
        if_pc       = pc;
        pred_taken  = pt;
        pred_target = ptgt;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_taken  = tk;
        ex_target = tgt;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flush"},  {63'd0, flush},          64'd0);
        check({tag, "_stall"},  {63'd0, stall_if},       64'd0);
        check({tag, "_redir"},  {63'd0, redirect_valid}, 64'd0);
        check({tag, "_upd"},    {63'd0, upd_valid},      64'd0);
        check({tag, "_count"},  {61'd0, count},          64'd0);
    endtask

    initial begin
        idle_in();
        reset = 1'b0;

        // Reset held with random inputs: everything stays at zero.
        for (int i = 0; i < 3; i++) begin
            if_valid    = 1'($urandom);
            if_opCode   = OP_BR;
            if_pc       = $urandom;
            pred_taken  = 1'($urandom);
            pred_target = $urandom;
            ex_valid    = 1'($urandom);
            ex_taken    = 1'($urandom);
            ex_target   = $urandom;
            tick();
            check_quiet("rst");
            check("rst_rpc", {32'd0, redirect_pc}, 64'd0);
            check("rst_utk", {63'd0, upd_taken}, 64'd0);
        end
        idle_in();
        reset = 1'b1;
        tick();
        check_quiet("rel");

        // First allocation after reset, then a correct not-taken resolve.
        fetch(OP_BR, 32'h100, 1'b0, 32'h0);
        tick(); idle_in();
        check("alloc_count", {61'd0, count}, 64'd1);
        check("alloc_stall", {63'd0, stall_if}, 64'd0);
        resolve(1'b0, 32'h0);
        tick(); idle_in();
        check("okbr_upd",   {63'd0, upd_valid}, 64'd1);
        check("okbr_utk",   {63'd0, upd_taken}, 64'd0);
        check("okbr_flush", {63'd0, flush}, 64'd0);
        check("okbr_redir", {63'd0, redirect_valid}, 64'd0);
        check("okbr_count", {61'd0, count}, 64'd0);
        tick();
        check("okbr_updpulse", {63'd0, upd_valid}, 64'd0);

        // Direction mispredict on a branch, taken to 0x400.
        fetch(OP_BR, 32'h200, 1'b0, 32'h0);
        tick(); idle_in();
        check("mp_count0", {61'd0, count}, 64'd1);
        resolve(1'b1, 32'h400);
        tick(); idle_in();
        check("mp_redir",  {63'd0, redirect_valid}, 64'd1);
        check("mp_rpc",    {32'd0, redirect_pc}, 64'h400);
        check("mp_flush1", {63'd0, flush}, 64'd1);
        check("mp_stall1", {63'd0, stall_if}, 64'd1);
        check("mp_count1", {61'd0, count}, 64'd0);
        check("mp_upd",    {63'd0, upd_valid}, 64'd1);
        check("mp_utk",    {63'd0, upd_taken}, 64'd1);
        // During the flush window: EX resolve and IF allocation are both ignored.
        resolve(1'b1, 32'h123);
        fetch(OP_BR, 32'h240, 1'b0, 32'h0);
        tick(); idle_in();
        check("mp_flush2", {63'd0, flush}, 64'd1);
        check("mp_stall2", {63'd0, stall_if}, 64'd1);
        check("mp_redir2", {63'd0, redirect_valid}, 64'd0);
        check("mp_upd2",   {63'd0, upd_valid}, 64'd0);
        check("mp_count2", {61'd0, count}, 64'd0);
        tick();
        check("mp_flush3", {63'd0, flush}, 64'd0);
        check("mp_stall3", {63'd0, stall_if}, 64'd0);
        check("mp_count3", {61'd0, count}, 64'd0);

        // JALR predicted taken to the wrong target.
        fetch(OP_JALR, 32'h300, 1'b1, 32'h500);
        tick(); idle_in();
        resolve(1'b1, 32'h504);
        tick(); idle_in();
        check("jalr_redir", {63'd0, redirect_valid}, 64'd1);
        check("jalr_rpc",   {32'd0, redirect_pc}, 64'h504);
        check("jalr_upd",   {63'd0, upd_valid}, 64'd0);
        check("jalr_flush", {63'd0, flush}, 64'd1);
        tick(); tick();
        check("jalr_done",  {63'd0, flush}, 64'd0);

        // Predicted taken but not taken at the top of the address space: pc+4 wraps to 0.
        fetch(OP_BR, 32'hFFFF_FFFC, 1'b1, 32'h700);
        tick(); idle_in();
        resolve(1'b0, 32'h0);
        tick(); idle_in();
        check("wrap_redir", {63'd0, redirect_valid}, 64'd1);
        check("wrap_rpc",   {32'd0, redirect_pc}, 64'h0);
        check("wrap_upd",   {63'd0, upd_valid}, 64'd1);
        check("wrap_utk",   {63'd0, upd_taken}, 64'd0);
        tick(); tick();

        // A non-control-flow opcode is never queued.
        fetch(7'h33, 32'h10, 1'b0, 32'h0);
        tick(); idle_in();
        check("alu_count", {61'd0, count}, 64'd0);
        check("alu_stall", {63'd0, stall_if}, 64'd0);

        // Fill the queue. The last entry predicts taken to 0x4000.
        for (int i = 0; i < 4; i++) begin
            fetch(OP_BR, 32'h1000 + 32'(4 * i), (i == 3), 32'h4000);
            tick();
        end
        idle_in();
        check("full_count", {61'd0, count}, 64'd4);
        check("full_stall", {63'd0, stall_if}, 64'd1);
        fetch(OP_BR, 32'h1010, 1'b0, 32'h0);
        tick(); idle_in();
        check("full_drop",  {61'd0, count}, 64'd4);
        resolve(1'b0, 32'h0);
        tick(); idle_in();
        check("pop1_count", {61'd0, count}, 64'd3);
        check("pop1_upd",   {63'd0, upd_valid}, 64'd1);
        check("pop1_flush", {63'd0, flush}, 64'd0);
        // Simultaneous correct resolve and new JAL allocation.
        resolve(1'b0, 32'h0);
        fetch(OP_JAL, 32'h2000, 1'b1, 32'h3000);
        tick(); idle_in();
        check("sim_count", {61'd0, count}, 64'd3);
        check("sim_redir", {63'd0, redirect_valid}, 64'd0);
        resolve(1'b0, 32'h0);
        tick(); idle_in();
        check("pop3_count", {61'd0, count}, 64'd2);
        // The head is now the fourth branch (pc 0x100C, predicted taken).
        // It resolves not-taken while a new branch is fetched. The clear wins.
        resolve(1'b0, 32'h0);
        fetch(OP_BR, 32'h2100, 1'b0, 32'h0);
        tick(); idle_in();
        check("clr_redir", {63'd0, redirect_valid}, 64'd1);
        check("clr_rpc",   {32'd0, redirect_pc}, 64'h1010);
        check("clr_count", {61'd0, count}, 64'd0);
        check("clr_flush", {63'd0, flush}, 64'd1);
        tick(); tick();
        check("clr_done",  {63'd0, flush}, 64'd0);
        check("clr_empty", {61'd0, count}, 64'd0);

        // A resolve on an empty queue is ignored.
        resolve(1'b1, 32'h999);
        tick(); idle_in();
        check_quiet("empty");

        // A correctly predicted JAL: pop only, no update strobe.
        fetch(OP_JAL, 32'h800, 1'b1, 32'h880);
        tick(); idle_in();
        resolve(1'b1, 32'h880);
        tick(); idle_in();
        check_quiet("okjal");

`ifdef BRC_STATS_EN
        check("stat_res", {48'd0, stat_resolved}, 64'd9);
        check("stat_mp",  {48'd0, stat_mispred},  64'd4);
`endif

        // Reset asserted in the middle of a flush window aborts it at once.
        fetch(OP_BR, 32'h40, 1'b0, 32'h0);
        tick(); idle_in();
        resolve(1'b1, 32'h80);
        tick(); idle_in();
        check("rf_flush", {63'd0, flush}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check_quiet("rf_async");
        #1 reset = 1'b1;
        tick();
        check_quiet("rf_after");
`ifdef BRC_STATS_EN
        check("rf_stat", {48'd0, stat_resolved}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
